// File: rtl/iter_shifter_if.sv
// rtl/iter_shifter_if.sv - start/busy/done request bus of the multi-cycle shift unit
//
// Ports (all carried as interface signals):
//   start   request; taken by the shifter only while it is not busy
//   op      00 SLL, 01 SRL, 11 SRA, 10 ROTR
//   v       1: amount from rs[SHAMT_W-1:0], 0: amount from sa
//   sa      immediate shift amount
//   rs      variable-amount source (only the low SHAMT_W bits matter)
//   rt      operand to shift
//   busy    shifter is stepping through a shift
//   done    one-cycle pulse, result valid
//   result  shifted value, held until the next accepted request completes
// Modports: master drives the request side, slave is the shifter.
interface iter_shifter_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
);
  logic               start;
  logic [1:0]         op;
  logic               v;
  logic [SHAMT_W-1:0] sa;
  logic [WIDTH-1:0]   rs;
  logic [WIDTH-1:0]   rt;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   result;

  modport master (
    output start, op, v, sa, rs, rt,
    input  busy, done, result
  );

  modport slave (
    input  start, op, v, sa, rs, rt,
    output busy, done, result
  );
endinterface

// File: rtl/iter_shifter.sv
// rtl/iter_shifter.sv - multi-cycle SLL/SRL/SRA/ROTR shift unit, at most STEP bits per cycle
//
// Ports:
//   clk    clock, all state changes on the rising edge
//   reset  synchronous, active-high; wins over a simultaneous start
//   bus    iter_shifter_if slave modport (start/op/v/sa/rs/rt in, busy/done/result out)
// Parameters:
//   WIDTH    data width, power of 2, >= 8
//   SHAMT_W  shift-amount width
//   STEP     maximum bit positions shifted per cycle, power of 2, 1..WIDTH
module iter_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int STEP    = 4
) (
  input  logic           clk,
  input  logic           reset,
  iter_shifter_if.slave  bus
);

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRL  = 2'b01;
  localparam logic [1:0] OP_ROTR = 2'b10;
  localparam logic [1:0] OP_SRA  = 2'b11;

  // The remaining counter is one bit wider than the amount so STEP == WIDTH
  // and WIDTH itself are representable without wrap.
  localparam logic [SHAMT_W:0] STEP_C  = (SHAMT_W+1)'(STEP);
  localparam logic [SHAMT_W:0] WIDTH_C = (SHAMT_W+1)'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  state_t             state_q,  state_d;
  logic [WIDTH-1:0]   data_q,   data_d;
  logic [SHAMT_W:0]   rem_q,    rem_d;
  logic [1:0]         op_q,     op_d;
  logic               sign_q,   sign_d;
  logic [WIDTH-1:0]   result_q, result_d;

  logic [SHAMT_W-1:0] amt_in;
  logic [SHAMT_W:0]   step;
  logic [WIDTH-1:0]   shifted;

  // Only the low SHAMT_W bits of rs select the amount.
  logic unused_rs_hi;
  assign unused_rs_hi = ^bus.rs[WIDTH-1:SHAMT_W];

  // One partial shift by n (0 < n <= STEP). SRA fills from the sign bit that
  // was latched at accept rather than the current MSB, which keeps the fill
  // explicit even though the two are always equal.
  function automatic logic [WIDTH-1:0] shift_by(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       o,
    input logic             s,
    input logic [SHAMT_W:0] n
  );
    logic [WIDTH-1:0] fill_mask;
    logic [WIDTH-1:0] r;
    fill_mask = ~({WIDTH{1'b1}} >> n);
    case (o)
      OP_SLL:  r = d << n;
      OP_SRL:  r = d >> n;
      OP_SRA:  r = (d >> n) | (s ? fill_mask : '0);
      OP_ROTR: r = (d >> n) | (d << (WIDTH_C - n));
      default: r = d;
    endcase
    return r;
  endfunction

  assign amt_in  = bus.v ? bus.rs[SHAMT_W-1:0] : bus.sa;
  assign step    = (rem_q < STEP_C) ? rem_q : STEP_C;
  assign shifted = shift_by(data_q, op_q, sign_q, step);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      data_q   <= '0;
      rem_q    <= '0;
      op_q     <= '0;
      sign_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      rem_q    <= rem_d;
      op_q     <= op_d;
      sign_q   <= sign_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    rem_d    = rem_q;
    op_d     = op_q;
    sign_d   = sign_q;
    result_d = result_q;

    case (state_q)
      // DONE accepts a new request exactly like IDLE so ops can run back to back.
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          data_d = bus.rt;
          op_d   = bus.op;
          sign_d = bus.rt[WIDTH-1];
          rem_d  = {1'b0, amt_in};
          if (amt_in == '0) begin
            state_d  = S_DONE;
            result_d = bus.rt;
          end else begin
            state_d = S_SHIFT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      // start is ignored here: a request while busy is dropped, not queued.
      S_SHIFT: begin
        data_d = shifted;
        rem_d  = rem_q - step;
        if (rem_q == step) begin
          state_d  = S_DONE;
          result_d = shifted;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy   = (state_q == S_SHIFT);
  assign bus.done   = (state_q == S_DONE);
  assign bus.result = result_q;

endmodule

// File: tb/tb_iter_shifter.sv
// tb/tb_iter_shifter.sv - scoreboard bench for iter_shifter
module tb_iter_shifter;

  localparam logic [1:0] SLL  = 2'b00;
  localparam logic [1:0] SRL  = 2'b01;
  localparam logic [1:0] ROTR = 2'b10;
  localparam logic [1:0] SRA  = 2'b11;

  typedef struct {
    logic [31:0] res;
    int          due;
    string       name;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   failures;
  exp_t sb_q[$];
  logic [31:0] last_result;

  iter_shifter_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

  iter_shifter #(.WIDTH(32), .SHAMT_W(5), .STEP(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse, checks value and cycle.
  always @(negedge clk) begin
    if (reset) begin
      last_result = 32'h0;
    end else begin
      if (bus.busy && bus.done) chk("busy_and_done", 32'd1, 32'd0);
      if (bus.busy) chk("result_hold", bus.result, last_result);
      if (bus.done) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk({e.name, "_result"}, bus.result, e.res);
          chk({e.name, "_latency"}, 32'(cyc), 32'(e.due));
        end
        last_result = bus.result;
      end
    end
  end

  // Issue one request; called just after a rising edge.
  task automatic issue(input string name, input logic [1:0] op, input logic v,
                       input logic [4:0] sa, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [31:0] exp_res);
    int n;
    int amt;
    exp_t e;
    n = 0;
    while (bus.busy && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (bus.busy) chk({name, "_wait_idle_timeout"}, 32'd1, 32'd0);
    amt = v ? int'(rs[4:0]) : int'(sa);
    bus.op = op; bus.v = v; bus.sa = sa; bus.rs = rs; bus.rt = rt;
    bus.start = 1'b1;
    e.res  = exp_res;
    e.due  = cyc + 1 + (amt + 3) / 4;
    e.name = name;
    sb_q.push_back(e);
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      chk({name, "_drain_timeout"}, 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0; last_result = 32'h0;
    reset = 1'b1;
    bus.start = 1'b0; bus.op = 2'b00; bus.v = 1'b0; bus.sa = 5'd0;
    bus.rs = 32'h0; bus.rt = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy",   32'(bus.busy), 32'd0);
    chk("reset_done",   32'(bus.done), 32'd0);
    chk("reset_result", bus.result,    32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    issue("sra4",      SRA,  1'b0, 5'd4,  32'h0,        32'h8000_0000, 32'hF800_0000);
    drain("sra4");
    issue("sra31",     SRA,  1'b0, 5'd31, 32'h0,        32'h8000_0000, 32'hFFFF_FFFF);
    drain("sra31");
    issue("srl_rs",    SRL,  1'b1, 5'd17, 32'h0000_0024, 32'hF000_0000, 32'h0F00_0000);
    drain("srl_rs");
    issue("rotr8",     ROTR, 1'b0, 5'd8,  32'h0,        32'h1234_5678, 32'h7812_3456);
    drain("rotr8");
    issue("sll0",      SLL,  1'b0, 5'd0,  32'h0,        32'hDEAD_BEEF, 32'hDEAD_BEEF);
    drain("sll0");

    // back-to-back: each request lands in the previous op's DONE cycle
    issue("sll5",      SLL,  1'b0, 5'd5,  32'h0,        32'h0000_0001, 32'h0000_0020);
    issue("rotr1",     ROTR, 1'b0, 5'd1,  32'h0,        32'h0000_0001, 32'h8000_0000);
    issue("sra7_pos",  SRA,  1'b0, 5'd7,  32'h0,        32'h7FFF_FFFF, 32'h00FF_FFFF);
    issue("srl31",     SRL,  1'b0, 5'd31, 32'h0,        32'hFFFF_FFFF, 32'h0000_0001);
    issue("sll_rs3",   SLL,  1'b1, 5'd9,  32'hFFFF_FFE3, 32'h0000_0011, 32'h0000_0088);
    issue("rotr31",    ROTR, 1'b0, 5'd31, 32'h0,        32'h8000_0001, 32'h0000_0003);
    issue("sra3",      SRA,  1'b0, 5'd3,  32'h0,        32'h8000_0010, 32'hF000_0002);
    issue("sll0_b2b",  SLL,  1'b0, 5'd0,  32'h0,        32'hCAFE_F00D, 32'hCAFE_F00D);
    drain("b2b");

    // start pulsed while busy must be dropped
    issue("sra31_mid", SRA,  1'b0, 5'd31, 32'h0,        32'h8000_0000, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.op = SLL; bus.v = 1'b0; bus.sa = 5'd0; bus.rt = 32'h1234_5678;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    drain("sra31_mid");
    repeat (4) @(posedge clk);
    #1;

    // reset mid-SHIFT, with a simultaneous start that reset must override
    issue("rst_victim", SRA, 1'b0, 5'd31, 32'h0,        32'h8000_0000, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    bus.op = SLL; bus.v = 1'b0; bus.sa = 5'd0; bus.rt = 32'hAAAA_5555;
    bus.start = 1'b1;
    sb_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    bus.start = 1'b0;
    chk("midrst_busy",   32'(bus.busy), 32'd0);
    chk("midrst_done",   32'(bus.done), 32'd0);
    chk("midrst_result", bus.result,    32'h0);
    repeat (3) @(posedge clk);
    #1;
    issue("post_rst",  SRL,  1'b0, 5'd12, 32'h0,        32'hABCD_0000, 32'h000A_BCD0);
    drain("post_rst");

    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
